alu_req_unit: RTL and testbench



---
 rtl/alu_req_unit.sv | 187 ++++++++++++++++++
 tb/tb_alu_req_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_unit.sv
// Handshaked ALU execution unit: one request in, one registered result with flags out.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (s=3'b111); otherwise it returns zero.
module alu_req_unit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero
);

`ifdef ALU_MUL_EN
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd2
  } state_e;
`endif

  state_e state_q, state_d;

  logic             req_ready_q,  req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] y_q,          y_d;
  logic             carry_q,      carry_d;
  logic             zero_q,       zero_d;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] a_q,   a_d;
  logic [WIDTH-1:0] b_q,   b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] acc_sum;
  logic             mul_last;
`endif

  // Single-cycle result computed straight from the request inputs
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  always_comb begin : alu_p
    sum_w  = {1'b0, a} + {1'b0, b};
    diff_w = {1'b0, a} - {1'b0, b};
    alu_y  = '0;
    alu_c  = 1'b0;
    case (s)
      3'b000: begin alu_y = sum_w[WIDTH-1:0];  alu_c = sum_w[WIDTH];  end
      3'b001: begin alu_y = diff_w[WIDTH-1:0]; alu_c = diff_w[WIDTH]; end
      3'b010: alu_y = a & b;
      3'b011: alu_y = a | b;
      3'b100: alu_y = a ^ b;
      3'b101: alu_y = ~a;
      3'b110: begin alu_y = {a[WIDTH-2:0], 1'b0}; alu_c = a[WIDTH-1]; end
      default: begin alu_y = '0; alu_c = 1'b0; end
    endcase
  end

`ifdef ALU_MUL_EN
  always_comb begin : mul_step_p
    acc_sum  = acc_q + (b_q[cnt_q] ? (ACC_W'(a_q) << cnt_q) : '0);
    mul_last = (cnt_q == CNT_W'(WIDTH - 1));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin : state_reg_p
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin : next_state_p
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef ALU_MUL_EN
          state_d = (s == 3'b111) ? EXEC : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef ALU_MUL_EN
      EXEC: if (mul_last) state_d = RESP;
`endif
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags follow the next state so they are valid straight out of a flop
  always_comb begin : output_p
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    y_d          = y_q;
    carry_d      = carry_q;
`ifdef ALU_MUL_EN
    a_d   = a_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
`ifdef ALU_MUL_EN
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
          acc_d = '0;
          if (s != 3'b111) begin
            y_d     = alu_y;
            carry_d = alu_c;
          end
`else
          y_d     = alu_y;
          carry_d = alu_c;
`endif
        end
      end
`ifdef ALU_MUL_EN
      EXEC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        if (mul_last) begin
          y_d     = acc_sum[WIDTH-1:0];
          carry_d = |acc_sum[ACC_W-1:WIDTH];
        end
      end
`endif
      default: ;
    endcase
    zero_d = (y_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin : out_reg_p
    if (rst) begin
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      y_q          <= '0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b1;
`ifdef ALU_MUL_EN
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
`endif
    end else begin
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      y_q          <= y_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
`ifdef ALU_MUL_EN
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign y          = y_q;
  assign carry      = carry_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_alu_req_unit.sv
// Directed bench for alu_req_unit (WIDTH=4); expectations follow ALU_MUL_EN when defined.
module tb_alu_req_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] s;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] y;
  logic       carry;
  logic       zero;

  int vectors = 0;
  int errors  = 0;

`ifdef ALU_MUL_EN
  localparam int         MUL_LAT = 5;
  localparam logic [3:0] MUL1_Y  = 4'b1010;
  localparam logic       MUL1_C  = 1'b1;
  localparam logic [3:0] MUL2_Y  = 4'b0110;
`else
  localparam int         MUL_LAT = 1;
  localparam logic [3:0] MUL1_Y  = 4'b0000;
  localparam logic       MUL1_C  = 1'b0;
  localparam logic [3:0] MUL2_Y  = 4'b0000;
`endif

  alu_req_unit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .s          (s),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .y          (y),
    .carry      (carry),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  // Drive one request; lat = edges from capture until resp_valid (capture edge counts as 1), -1 on timeout
  task automatic issue(input logic [3:0] ta, input logic [3:0] tb, input logic [2:0] ts,
                       output int lat);
    int g;
    a = ta; b = tb; s = ts; req_valid = 1'b1;
    lat = -1;
    g = 0;
    while (!req_ready && g < 20) begin @(posedge clk); #1; g++; end
    if (req_ready) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      g = 1;
      while (!resp_valid && g < 20) begin @(posedge clk); #1; g++; end
      if (resp_valid) lat = g;
    end
    req_valid = 1'b0;
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; a = '0; b = '0; s = '0;
    #12;
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    vectors++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y got %b want 0000", y); end
    vectors++; if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry); end
    vectors++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    int lat;
    issue(4'b1001, 4'b1010, 3'b000, lat);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
    vectors++; if (y !== 4'b0011) begin errors++; $display("FAIL add_y got %b want 0011", y); end
    vectors++; if (carry !== 1'b1) begin errors++; $display("FAIL add_carry got %b want 1", carry); end
    vectors++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b want 0", zero); end
    retire();
  endtask

  task automatic test_sweep();
    logic [3:0] exp_y [6] = '{4'b1111, 4'b1000, 4'b1011, 4'b0011, 4'b0110, 4'b0010};
    logic       exp_c [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(4'b1001, 4'b1010, 3'(i + 1), lat);
      vectors++; if (lat !== 1) begin errors++; $display("FAIL sweep_latency s=%0d got %0d want 1", i + 1, lat); end
      vectors++; if (y !== exp_y[i]) begin errors++; $display("FAIL sweep_y s=%0d got %b want %b", i + 1, y, exp_y[i]); end
      vectors++; if (carry !== exp_c[i]) begin errors++; $display("FAIL sweep_carry s=%0d got %b want %b", i + 1, carry, exp_c[i]); end
      retire();
    end
  endtask

  task automatic test_multiply();
    int lat;
    issue(4'b1001, 4'b1010, 3'b111, lat);
    vectors++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul1_latency got %0d want %0d", lat, MUL_LAT); end
    vectors++; if (y !== MUL1_Y) begin errors++; $display("FAIL mul1_y got %b want %b", y, MUL1_Y); end
    vectors++; if (carry !== MUL1_C) begin errors++; $display("FAIL mul1_carry got %b want %b", carry, MUL1_C); end
    vectors++; if (zero !== (MUL1_Y == 4'b0000)) begin errors++; $display("FAIL mul1_zero got %b", zero); end
    retire();
    issue(4'b0011, 4'b0010, 3'b111, lat);
    vectors++; if (lat !== MUL_LAT) begin errors++; $display("FAIL mul2_latency got %0d want %0d", lat, MUL_LAT); end
    vectors++; if (y !== MUL2_Y) begin errors++; $display("FAIL mul2_y got %b want %b", y, MUL2_Y); end
    vectors++; if (carry !== 1'b0) begin errors++; $display("FAIL mul2_carry got %b want 0", carry); end
    retire();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    issue(4'b0001, 4'b0010, 3'b000, lat);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL bp_latency got %0d want 1", lat); end
    a = 4'b0100; b = 4'b0001; s = 3'b000; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid !== 1'b1 || y !== 4'b0011 || carry !== 1'b0 || zero !== 1'b0 || req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL bp_hold_stable got %0d bad cycles want 0", bad); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_retire_valid got %b want 0", resp_valid); end
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_retire_ready got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++; if (resp_valid !== 1'b1 || y !== 4'b0101) begin errors++; $display("FAIL bp_second_result got valid=%b y=%b want valid=1 y=0101", resp_valid, y); end
    retire();
  endtask

  task automatic test_zero();
    int lat;
    issue(4'b0101, 4'b0101, 3'b001, lat);
    vectors++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    vectors++; if (y !== 4'b0000) begin errors++; $display("FAIL zero_y got %b want 0000", y); end
    vectors++; if (zero !== 1'b1) begin errors++; $display("FAIL zero_flag got %b want 1", zero); end
    vectors++; if (carry !== 1'b0) begin errors++; $display("FAIL zero_carry got %b want 0", carry); end
    retire();
  endtask

  task automatic test_back_to_back();
    int lat;
    resp_ready = 1'b1;
    issue(4'b0010, 4'b0011, 3'b000, lat);
    vectors++; if (lat !== 1 || y !== 4'b0101) begin errors++; $display("FAIL b2b_first got lat=%0d y=%b want lat=1 y=0101", lat, y); end
    @(posedge clk); #1;
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_retire got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
    issue(4'b0111, 4'b0001, 3'b011, lat);
    vectors++; if (lat !== 1 || y !== 4'b0111) begin errors++; $display("FAIL b2b_second got lat=%0d y=%b want lat=1 y=0111", lat, y); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int stale = 0;
    a = 4'b1001; b = 4'b1010; s = 3'b111; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmul_resp_valid got %b want 0", resp_valid); end
    vectors++; if (y !== 4'b0000 || zero !== 1'b1) begin errors++; $display("FAIL rstmul_y got y=%b zero=%b want 0000 1", y, zero); end
    vectors++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmul_req_ready got %b want 1", req_ready); end
    @(negedge clk); rst = 1'b0;
    issue(4'b0001, 4'b0001, 3'b000, lat);
    vectors++; if (lat !== 1 || y !== 4'b0010) begin errors++; $display("FAIL rstmul_add got lat=%0d y=%b want lat=1 y=0010", lat, y); end
    retire();
    for (int i = 0; i < 8; i++) begin
      if (resp_valid !== 1'b0) stale++;
      @(posedge clk); #1;
    end
    vectors++; if (stale != 0) begin errors++; $display("FAIL rstmul_stale got %0d valid cycles want 0", stale); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sweep();
    test_multiply();
    test_backpressure();
    test_zero();
    test_back_to_back();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
